// File: rtl/core_csr_counters_if.sv
// CSR request/response bus between the CSR unit (master) and the counter bank (slave).
// Carries the registered read port and the write port with its error pulse.
interface core_csr_counters_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // Read request and registered response
  logic                  rd_en;
  logic [11:0]           rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  // Write request (data already RW/RS/RC-resolved upstream) and error pulse
  logic                  wr_en;
  logic [11:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    input  rd_err,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_err
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    output rd_err,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_err
  );
endinterface

// File: rtl/core_csr_counters.sv
// Zicntr/Zihpm-style counter bank: free-running cycle, time and instret counters exposed as
// 32-bit low/high CSR halves, with a 1-cycle registered read port and a write port for the
// machine-mode aliases (mcycle/minstret).
// Optional feature: define CSR_COUNTINHIBIT_EN to implement mcountinhibit at 0x320
// (bit0 freezes cycle, bit2 freezes instret). Without it 0x320 is an unmapped address.
module core_csr_counters #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 64,  // must equal 2*DATA_WIDTH
  parameter int unsigned TIME_DIV   = 1    // legal >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  core_csr_counters_if.slave   bus,
  input  logic                 retire_i,
  output logic [CNT_WIDTH-1:0] cycle_o
);

  localparam logic [11:0] AddrCycle     = 12'hC00;
  localparam logic [11:0] AddrTime      = 12'hC01;
  localparam logic [11:0] AddrInstret   = 12'hC02;
  localparam logic [11:0] AddrCycleh    = 12'hC80;
  localparam logic [11:0] AddrTimeh     = 12'hC81;
  localparam logic [11:0] AddrInstreth  = 12'hC82;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;

  // Prescaler needs at least one bit even when TIME_DIV == 1 (it then stays at 0).
  localparam int unsigned PreW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  // Next value of a writable counter. A low-half write replaces bits[31:0] and suppresses the
  // increment; a high-half write replaces bits[63:32] while the low half keeps counting with
  // its carry discarded.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0]  cur,
    input logic                  inc,
    input logic                  wr_lo,
    input logic                  wr_hi,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH-1:0] lo_inc;
    lo_inc = cur[DATA_WIDTH-1:0] + DATA_WIDTH'(inc);
    if (wr_lo) begin
      return {cur[CNT_WIDTH-1:DATA_WIDTH], data};
    end
    if (wr_hi) begin
      return {data, lo_inc};
    end
    return cur + CNT_WIDTH'(inc);
  endfunction

  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [CNT_WIDTH-1:0]  time_q, time_d;
  logic [PreW-1:0]       presc_q, presc_d;
  logic                  time_tick;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_err_q;
  logic                  wr_err_q;

  logic                  wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi, wr_inh, wr_legal;
  logic                  cy_run, ir_run;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  // Decode of the write port; only the machine-mode aliases (and mcountinhibit) are writable.
  always_comb begin
    wr_cy_lo = bus.wr_en && (bus.wr_addr == AddrMcycle);
    wr_cy_hi = bus.wr_en && (bus.wr_addr == AddrMcycleh);
    wr_ir_lo = bus.wr_en && (bus.wr_addr == AddrMinstret);
    wr_ir_hi = bus.wr_en && (bus.wr_addr == AddrMinstreth);
    wr_legal = wr_cy_lo || wr_cy_hi || wr_ir_lo || wr_ir_hi || wr_inh;
  end

`ifdef CSR_COUNTINHIBIT_EN
  localparam logic [11:0] AddrMcountinhibit = 12'h320;

  logic                  inh_cy_q, inh_ir_q;
  logic [DATA_WIDTH-1:0] inh_rd;

  assign wr_inh = bus.wr_en && (bus.wr_addr == AddrMcountinhibit);
  assign cy_run = ~inh_cy_q;
  assign ir_run = ~inh_ir_q;
  assign inh_rd = {{(DATA_WIDTH-3){1'b0}}, inh_ir_q, 1'b0, inh_cy_q};

  // mcountinhibit: only CY (bit0) and IR (bit2) are stored; other bits are hardwired to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cy_q <= 1'b0;
      inh_ir_q <= 1'b0;
    end else if (wr_inh) begin
      inh_cy_q <= bus.wr_data[0];
      inh_ir_q <= bus.wr_data[2];
    end
  end
`else
  assign wr_inh = 1'b0;
  assign cy_run = 1'b1;
  assign ir_run = 1'b1;
`endif

  // Counter next-state: writes take priority over the increment of the same cycle.
  always_comb begin
    cycle_d   = cnt_next(cycle_q, cy_run, wr_cy_lo, wr_cy_hi, bus.wr_data);
    instret_d = cnt_next(instret_q, retire_i && ir_run, wr_ir_lo, wr_ir_hi, bus.wr_data);
    time_tick = (presc_q == PreW'(TIME_DIV - 1));
    presc_d   = time_tick ? '0 : presc_q + PreW'(1);
    time_d    = time_q + CNT_WIDTH'(time_tick);
  end

  // Counter state; time is never writable and never inhibited.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
      time_q    <= '0;
      presc_q   <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      time_q    <= time_d;
      presc_q   <= presc_d;
    end
  end

  // Read mux over the pre-update counter state; unmapped addresses return 0 with an error.
  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (bus.rd_addr)
      AddrCycle, AddrMcycle:       rd_val = cycle_q[DATA_WIDTH-1:0];
      AddrCycleh, AddrMcycleh:     rd_val = cycle_q[CNT_WIDTH-1:DATA_WIDTH];
      AddrTime:                    rd_val = time_q[DATA_WIDTH-1:0];
      AddrTimeh:                   rd_val = time_q[CNT_WIDTH-1:DATA_WIDTH];
      AddrInstret, AddrMinstret:   rd_val = instret_q[DATA_WIDTH-1:0];
      AddrInstreth, AddrMinstreth: rd_val = instret_q[CNT_WIDTH-1:DATA_WIDTH];
`ifdef CSR_COUNTINHIBIT_EN
      AddrMcountinhibit:           rd_val = inh_rd;
`endif
      default:                     rd_hit = 1'b0;
    endcase
    rd_data_d = (bus.rd_en && rd_hit) ? rd_val : '0;
  end

  // Registered read response and write-error pulse; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.rd_en;
      rd_err_q   <= bus.rd_en && !rd_hit;
      wr_err_q   <= bus.wr_en && !wr_legal;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;
  assign cycle_o      = cycle_q;

endmodule
